// File: rtl/aud_loop_sram_if.sv
// ---------------------------------------------------------------------------
// aud_loop_sram_if
//   Bus to the external 16-bit asynchronous SRAM used by the looper.
//   master : the looper controller (drives address, data and strobes)
//   slave  : the SRAM side / pad wrapper (returns read data)
// Signals
//   sram_addr  word address
//   sram_wdata write data
//   sram_rdata read data (the top level resolves the bidirectional DQ pins)
//   dq_oe      1 = controller drives DQ
//   we_n, ce_n, oe_n, lb_n, ub_n  active-low SRAM strobes
// ---------------------------------------------------------------------------
interface aud_loop_sram_if #(
  parameter int ADDR_W = 20
);
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_wdata;
  logic [15:0]       sram_rdata;
  logic              dq_oe;
  logic              we_n;
  logic              ce_n;
  logic              oe_n;
  logic              lb_n;
  logic              ub_n;

  modport master (
    output sram_addr, sram_wdata, dq_oe, we_n, ce_n, oe_n, lb_n, ub_n,
    input  sram_rdata
  );

  modport slave (
    input  sram_addr, sram_wdata, dq_oe, we_n, ce_n, oe_n, lb_n, ub_n,
    output sram_rdata
  );
endinterface

// File: rtl/aud_loop_sram.sv
// ---------------------------------------------------------------------------
// aud_loop_sram
//   Looper datapath between the last effect stage and the I2S player.
//   REC  : every accepted sample is written to SRAM at wr_ptr.
//   PLAY : every accepted sample is mixed (saturating) with the stored loop
//          sample read from rd_ptr, which wraps at the loop length.
//   IDLE : samples pass straight through, SRAM untouched.
//   Every accepted sample produces o_valid exactly RD_CYCLES+2 cycles later.
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_valid, i_data         1-cycle sample strobe and signed live sample
//   i_rec, i_play, i_stop   command pulses (stop > rec > play)
//   o_valid, o_data         output strobe and signed output sample
//   o_mode                  0 IDLE, 1 REC, 2 PLAY
//   o_loop_len              stored loop length in samples
//   o_overrun               sticky: a sample arrived while an access was busy
//   sram                    SRAM bus (master side)
// ---------------------------------------------------------------------------
module aud_loop_sram #(
  parameter int ADDR_W    = 20,
  parameter int MAX_LEN   = 1048575,
  parameter int WR_CYCLES = 2,
  parameter int RD_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [15:0]       i_data,
  input  logic              i_rec,
  input  logic              i_play,
  input  logic              i_stop,
  output logic [15:0]       o_data,
  output logic              o_valid,
  output logic [1:0]        o_mode,
  output logic [ADDR_W-1:0] o_loop_len,
  output logic              o_overrun,
  aud_loop_sram_if.master   sram
);

  localparam int LAT      = RD_CYCLES + 2;
  // Busy window must cover both the write data-hold cycle and the output cycle.
  localparam int DONE_CNT = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES + 1 : RD_CYCLES + 1;
  localparam int CNT_W    = $clog2(DONE_CNT + 1);

  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_LEN - 1);
  localparam logic [ADDR_W-1:0] FULL_LEN  = ADDR_W'(MAX_LEN);

  typedef enum logic [1:0] {M_IDLE = 2'd0, M_REC = 2'd1, M_PLAY = 2'd2} mode_t;
  typedef enum logic [1:0] {A_IDLE, A_WR, A_RD, A_DONE} acc_t;

  mode_t             mode;
  mode_t             acc_mode;   // mode the current sample was accepted in
  acc_t              acc;
  logic [CNT_W-1:0]  cnt;        // cycles since the sample was accepted
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [15:0]       sample;
  logic [15:0]       loop_smp;
  logic              pend_rec, pend_play, pend_stop;

  // A fresh pulse replaces whatever was pending, so the last command wins.
  logic any_pulse, cmd_rec, cmd_play, cmd_stop, apply;
  logic [ADDR_W-1:0] play_len;
  logic [16:0]       sum17;
  logic [15:0]       mix;

  assign any_pulse = i_rec | i_play | i_stop;
  assign cmd_rec   = any_pulse ? i_rec  : pend_rec;
  assign cmd_play  = any_pulse ? i_play : pend_play;
  assign cmd_stop  = any_pulse ? i_stop : pend_stop;
  assign apply     = (acc == A_IDLE) && (cmd_rec || cmd_play || cmd_stop);
  assign play_len  = (mode == M_REC) ? wr_ptr : o_loop_len;

  assign sum17 = {sample[15], sample} + {loop_smp[15], loop_smp};
  assign mix   = (sum17[16] != sum17[15]) ? (sum17[16] ? 16'h8000 : 16'h7FFF)
                                          : sum17[15:0];

  assign o_mode = mode;

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge value of its neighbours.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mode            <= M_IDLE;
      acc_mode        <= M_IDLE;
      acc             <= A_IDLE;
      cnt             <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      o_loop_len      <= '0;
      sample          <= '0;
      loop_smp        <= '0;
      pend_rec        <= 1'b0;
      pend_play       <= 1'b0;
      pend_stop       <= 1'b0;
      o_data          <= '0;
      o_valid         <= 1'b0;
      o_overrun       <= 1'b0;
      sram.sram_addr  <= '0;
      sram.sram_wdata <= '0;
      sram.dq_oe      <= 1'b0;
      sram.we_n       <= 1'b1;
      sram.ce_n       <= 1'b1;
      sram.oe_n       <= 1'b1;
      sram.lb_n       <= 1'b1;
      sram.ub_n       <= 1'b1;
    end else begin
      o_valid <= 1'b0;

      if (any_pulse) begin
        pend_rec  <= i_rec;
        pend_play <= i_play;
        pend_stop <= i_stop;
      end

      if (apply) begin
        pend_rec  <= 1'b0;
        pend_play <= 1'b0;
        pend_stop <= 1'b0;
        if (cmd_stop) begin
          if (mode == M_REC) o_loop_len <= wr_ptr;
          mode <= M_IDLE;
        end else if (cmd_rec) begin
          wr_ptr     <= '0;
          o_loop_len <= '0;
          mode       <= M_REC;
        end else begin
          o_loop_len <= play_len;
          if (play_len == '0) begin
            mode <= M_IDLE;
          end else begin
            rd_ptr <= '0;
            mode   <= M_PLAY;
          end
        end
      end

      if (i_valid && acc != A_IDLE) o_overrun <= 1'b1;

      case (acc)
        A_IDLE: begin
          if (i_valid) begin
            sample <= i_data;
            cnt    <= CNT_W'(1);
            // A sample coinciding with a mode change passes through untouched
            // so pointers are never used in the middle of being reassigned.
            if (apply || mode == M_IDLE) begin
              acc_mode <= M_IDLE;
              acc      <= A_DONE;
            end else if (mode == M_REC) begin
              acc_mode        <= M_REC;
              acc             <= A_WR;
              sram.sram_addr  <= wr_ptr;
              sram.sram_wdata <= i_data;
              sram.dq_oe      <= 1'b1;
              sram.ce_n       <= 1'b0;
              sram.we_n       <= 1'b0;
              sram.lb_n       <= 1'b0;
              sram.ub_n       <= 1'b0;
            end else begin
              acc_mode       <= M_PLAY;
              acc            <= A_RD;
              sram.sram_addr <= rd_ptr;
              sram.dq_oe     <= 1'b0;
              sram.ce_n      <= 1'b0;
              sram.oe_n      <= 1'b0;
              sram.lb_n      <= 1'b0;
              sram.ub_n      <= 1'b0;
            end
          end
        end

        A_WR: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WR_CYCLES)) begin
            sram.we_n <= 1'b1;
            sram.ce_n <= 1'b1;
            sram.lb_n <= 1'b1;
            sram.ub_n <= 1'b1;
            acc       <= A_DONE;
            if (wr_ptr == LAST_ADDR) begin
              wr_ptr     <= FULL_LEN;
              o_loop_len <= FULL_LEN;
              rd_ptr     <= '0;
              mode       <= M_PLAY;
            end else begin
              wr_ptr <= wr_ptr + ONE;
            end
          end
        end

        A_RD: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(RD_CYCLES)) begin
            loop_smp  <= sram.sram_rdata;
            sram.oe_n <= 1'b1;
            sram.ce_n <= 1'b1;
            sram.lb_n <= 1'b1;
            sram.ub_n <= 1'b1;
            acc       <= A_DONE;
            rd_ptr    <= (rd_ptr == o_loop_len - ONE) ? '0 : rd_ptr + ONE;
          end
        end

        A_DONE: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WR_CYCLES + 1)) sram.dq_oe <= 1'b0;
          if (cnt == CNT_W'(DONE_CNT))      acc        <= A_IDLE;
        end

        default: acc <= A_IDLE;
      endcase

      if (acc != A_IDLE && cnt == CNT_W'(LAT - 1)) begin
        o_valid <= 1'b1;
        o_data  <= (acc_mode == M_PLAY) ? mix : sample;
      end
    end
  end

endmodule

// File: tb/tb_aud_loop_sram.sv
// ---------------------------------------------------------------------------
// tb_aud_loop_sram
//   Directed bench for aud_loop_sram with a small behavioural SRAM.
//   The looper is built with MAX_LEN = 4 so the full-loop transition is
//   reachable with a handful of samples.
// ---------------------------------------------------------------------------
module tb_aud_loop_sram;

  localparam int ADDR_W = 20;
  localparam int LAT    = 4;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_valid = 1'b0;
  logic [15:0]       i_data = '0;
  logic              i_rec = 1'b0, i_play = 1'b0, i_stop = 1'b0;
  logic [15:0]       o_data;
  logic              o_valid;
  logic [1:0]        o_mode;
  logic [ADDR_W-1:0] o_loop_len;
  logic              o_overrun;

  aud_loop_sram_if #(.ADDR_W(ADDR_W)) sram_bus ();

  aud_loop_sram #(
    .ADDR_W(ADDR_W), .MAX_LEN(4), .WR_CYCLES(2), .RD_CYCLES(2)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
    .i_rec(i_rec), .i_play(i_play), .i_stop(i_stop),
    .o_data(o_data), .o_valid(o_valid), .o_mode(o_mode),
    .o_loop_len(o_loop_len), .o_overrun(o_overrun), .sram(sram_bus)
  );

  always #5 i_clk = ~i_clk;

  // Behavioural SRAM: write while CE/WE low, combinational read while CE/OE low.
  logic [15:0] mem [0:15];
  always @(posedge i_clk)
    if (!sram_bus.ce_n && !sram_bus.we_n) mem[sram_bus.sram_addr[3:0]] <= sram_bus.sram_wdata;
  assign sram_bus.sram_rdata = (!sram_bus.ce_n && !sram_bus.oe_n) ? mem[sram_bus.sram_addr[3:0]]
                                                                   : 16'hDEAD;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observations from the last strobe() call.
  int          we_cyc, oe_cyc, ce_cyc, dq_cyc, vcnt, vk;
  logic        clash;
  logic [19:0] acc_addr;
  logic [15:0] acc_wdata, odat;

  task automatic cmd(input logic r, input logic p, input logic s);
    @(negedge i_clk);
    i_rec = r; i_play = p; i_stop = s;
    @(negedge i_clk);
    i_rec = 1'b0; i_play = 1'b0; i_stop = 1'b0;
  endtask

  // One sample, then watch LAT+1 cycles of bus and output activity.
  task automatic strobe(input logic [15:0] d);
    @(negedge i_clk);
    i_valid = 1'b1; i_data = d;
    we_cyc = 0; oe_cyc = 0; ce_cyc = 0; dq_cyc = 0; vcnt = 0; vk = 0;
    clash = 1'b0; acc_addr = '0; acc_wdata = '0; odat = '0;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      i_valid = 1'b0;
      if (!sram_bus.ce_n) ce_cyc++;
      if (sram_bus.dq_oe) dq_cyc++;
      if (!sram_bus.we_n) begin
        we_cyc++; acc_addr = sram_bus.sram_addr; acc_wdata = sram_bus.sram_wdata;
      end
      if (!sram_bus.oe_n) begin
        oe_cyc++; acc_addr = sram_bus.sram_addr;
        if (sram_bus.dq_oe) clash = 1'b1;
      end
      if (!sram_bus.we_n && !sram_bus.oe_n) clash = 1'b1;
      if (o_valid) begin vcnt++; vk = k; odat = o_data; end
    end
  endtask

  task automatic exp_acc(input string tag, input int e_we, input int e_oe, input int e_dq,
                         input logic [19:0] e_addr, input logic [15:0] e_odata);
    check({tag, "/we_cycles"}, we_cyc, e_we);
    check({tag, "/oe_cycles"}, oe_cyc, e_oe);
    check({tag, "/ce_cycles"}, ce_cyc, e_we + e_oe);
    check({tag, "/dq_oe_cycles"}, dq_cyc, e_dq);
    check({tag, "/clash"}, clash, 1'b0);
    if (e_we + e_oe > 0) check({tag, "/addr"}, acc_addr, e_addr);
    check({tag, "/valid_count"}, vcnt, 1);
    check({tag, "/valid_latency"}, vk, LAT);
    check({tag, "/o_data"}, odat, e_odata);
  endtask

  logic [15:0] rec_vals [3] = '{16'd10, 16'd20, 16'd30};
  logic [15:0] play_exp [3] = '{16'd11, 16'd21, 16'd31};

  initial begin
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;

    // Reset state
    check("rst/mode", o_mode, 2'd0);
    check("rst/valid", o_valid, 1'b0);
    check("rst/overrun", o_overrun, 1'b0);
    check("rst/loop_len", o_loop_len, 20'd0);
    check("rst/o_data", o_data, 16'd0);
    check("rst/addr", sram_bus.sram_addr, 20'd0);
    check("rst/dq_oe", sram_bus.dq_oe, 1'b0);
    check("rst/strobes_n", {sram_bus.we_n, sram_bus.ce_n, sram_bus.oe_n,
                            sram_bus.lb_n, sram_bus.ub_n}, 5'b11111);

    // 1: IDLE passthrough, no SRAM activity
    strobe(16'h1234);
    exp_acc("idle", 0, 0, 0, 20'd0, 16'h1234);

    // 2: record 10,20,30
    cmd(1'b1, 1'b0, 1'b0);
    check("rec/mode", o_mode, 2'd1);
    for (int i = 0; i < 3; i++) begin
      strobe(rec_vals[i]);
      exp_acc($sformatf("rec%0d", i), 2, 0, 3, 20'(i), rec_vals[i]);
      check($sformatf("rec%0d/wdata", i), acc_wdata, rec_vals[i]);
    end
    cmd(1'b0, 1'b0, 1'b1);
    check("rec/stop_mode", o_mode, 2'd0);
    check("rec/loop_len", o_loop_len, 20'd3);
    for (int i = 0; i < 3; i++) check($sformatf("rec/mem%0d", i), mem[i], rec_vals[i]);

    // 3: play with i_data = 1, wrap at 3
    cmd(1'b0, 1'b1, 1'b0);
    check("play/mode", o_mode, 2'd2);
    for (int i = 0; i < 7; i++) begin
      strobe(16'd1);
      exp_acc($sformatf("play%0d", i), 0, 2, 0, 20'(i % 3), play_exp[i % 3]);
    end

    // 4: saturation
    cmd(1'b1, 1'b0, 1'b0);
    strobe(16'h7000);
    strobe(16'h9000);
    cmd(1'b0, 1'b0, 1'b1);
    check("sat/loop_len", o_loop_len, 20'd2);
    cmd(1'b0, 1'b1, 1'b0);
    strobe(16'h7000);
    exp_acc("sat_pos", 0, 2, 0, 20'd0, 16'h7FFF);
    strobe(16'h9000);
    exp_acc("sat_neg", 0, 2, 0, 20'd1, 16'h8000);

    // 5: full loop auto-play, command priority, empty play
    cmd(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) strobe(16'(i + 100));
    check("full/last_addr", acc_addr, 20'd3);
    check("full/mode", o_mode, 2'd2);
    check("full/loop_len", o_loop_len, 20'd4);
    cmd(1'b1, 1'b1, 1'b1);
    check("prio/mode", o_mode, 2'd0);
    check("prio/loop_len", o_loop_len, 20'd4);
    cmd(1'b1, 1'b0, 1'b0);
    check("empty/rec_len", o_loop_len, 20'd0);
    cmd(1'b0, 1'b1, 1'b0);
    check("empty/mode", o_mode, 2'd0);
    check("empty/loop_len", o_loop_len, 20'd0);

    // 6a: overrun, second strobe 2 cycles after the first (in REC)
    cmd(1'b1, 1'b0, 1'b0);
    vcnt = 0; we_cyc = 0;
    @(negedge i_clk);
    i_valid = 1'b1; i_data = 16'd5;
    for (int k = 1; k <= 8; k++) begin
      @(negedge i_clk);
      i_valid = (k == 2);
      if (o_valid) vcnt++;
      if (!sram_bus.we_n) we_cyc++;
    end
    check("ovr/valid_count", vcnt, 1);
    check("ovr/we_cycles", we_cyc, 2);
    check("ovr/overrun", o_overrun, 1'b1);
    check("ovr/wr_ptr", dut.wr_ptr, 20'd1);

    // 6b: reset while WE_N is low
    @(negedge i_clk);
    i_valid = 1'b1; i_data = 16'd7;
    @(negedge i_clk);
    i_valid = 1'b0;
    check("rstw/we_low", sram_bus.we_n, 1'b0);
    i_rst = 1'b1;
    @(negedge i_clk);
    check("rstw/we_n", sram_bus.we_n, 1'b1);
    check("rstw/ce_n", sram_bus.ce_n, 1'b1);
    check("rstw/dq_oe", sram_bus.dq_oe, 1'b0);
    check("rstw/mode", o_mode, 2'd0);
    check("rstw/wr_ptr", dut.wr_ptr, 20'd0);
    check("rstw/overrun", o_overrun, 1'b0);
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
